// File: rtl/cpu_defs.sv
// cpu_defs: shared pipeline types for the memory2 stage.
//   reg_idx_t                 - architectural register index
//   ld_size_t                 - load access size (byte/half/word)
//   mem2_state_t              - memory2 load-tracking state
//   excp_event_t              - exception record carried down the pipe
//   memory1_memory2_pass_t    - memory1 -> memory2 pipeline payload
//   memory2_writeback_pass_t  - memory2 -> writeback pipeline payload
//   ld_pending()              - true when an instruction expects a D-cache response
package cpu_defs;

  typedef logic [4:0] reg_idx_t;

  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2
  } ld_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } mem2_state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] cause;
  } excp_event_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        is_ld;
    ld_size_t    ld_size;
    logic        ld_signed;
    logic [31:0] va;
    logic [31:0] ex_out;
    logic        is_wr_rd;
    reg_idx_t    rd;
    excp_event_t excp_event;
  } memory1_memory2_pass_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        is_ld;
    logic [31:0] va;
    logic [31:0] ex_mem_out;
    logic        is_wr_rd;
    reg_idx_t    rd;
    excp_event_t excp_event;
  } memory2_writeback_pass_t;

  // An excepting load was never sent to the D-cache, so no response follows.
  function automatic logic ld_pending(input memory1_memory2_pass_t p);
    return p.valid & p.is_ld & ~p.excp_event.valid;
  endfunction

endpackage

// File: rtl/memory2_if.sv
// memory2_if: pipeline and D-cache response bundle around the memory2 stage.
//   pass_in           - payload from memory1
//   dcache_data_valid - one-cycle load response strobe
//   dcache_rdata      - raw aligned word from the D-cache
//   pass_out          - payload to writeback
// master: the pipeline/D-cache side driving the stage; slave: memory2 itself.
interface memory2_if;
  import cpu_defs::*;

  memory1_memory2_pass_t   pass_in;
  logic                    dcache_data_valid;
  logic [31:0]             dcache_rdata;
  memory2_writeback_pass_t pass_out;

  modport master (
    output pass_in,
    output dcache_data_valid,
    output dcache_rdata,
    input  pass_out
  );

  modport slave (
    input  pass_in,
    input  dcache_data_valid,
    input  dcache_rdata,
    output pass_out
  );

endinterface

// File: rtl/load_align.sv
// load_align: selects the addressed byte/half from a 32-bit word and extends
// it to 32 bits (sign or zero). Purely combinational; shared with the
// uncached load path.
//   rdata_i     - raw aligned word
//   va_i        - low address bits of the access
//   ld_size_i   - access size
//   ld_signed_i - sign-extend when set, zero-extend otherwise
//   result_o    - extended load result
module load_align
  import cpu_defs::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  va_i,
  input  ld_size_t    ld_size_i,
  input  logic        ld_signed_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[8*va_i +: 8];
    half_sel = rdata_i[16*va_i[1] +: 16];
    result_o = rdata_i;
    case (ld_size_i)
      LD_B:    result_o = {{24{ld_signed_i & byte_sel[7]}}, byte_sel};
      LD_H:    result_o = {{16{ld_signed_i & half_sel[15]}}, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/memory2.sv
// memory2: second memory stage. Holds one instruction, waits for its D-cache
// load response, parks the response if writeback is stalled, aligns/extends
// load data and discards responses orphaned by a flush.
//   clk, rst_n  - core clock, async active-low reset
//   flush_i     - pipeline flush (wins over stall_i)
//   stall_i     - writeback stall
//   stall_o     - stall request to memory1
//   bus         - memory2_if.slave: pass_in, D-cache response, pass_out
// Build option MEM2_FWD_EN adds fwd_valid/fwd_rd/fwd_data for decode bypass;
// without it those ports do not exist and decode interlocks on this stage.
//
// state | meaning
// IDLE  | held instruction needs no response (non-load, excepting load, bubble)
// WAIT  | held load issued, response not yet seen
// HOLD  | response captured in hold_data_q while writeback stalls
// DROP  | flushed load still owes a response; swallow it, then IDLE
module memory2
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        stall_i,
  output logic        stall_o,
  memory2_if.slave    bus
`ifdef MEM2_FWD_EN
  ,
  output logic        fwd_valid,
  output reg_idx_t    fwd_rd,
  output logic [31:0] fwd_data
`endif
);

  memory1_memory2_pass_t   pass_in_q, pass_in_d;
  mem2_state_t             state_q, state_d;
  logic [31:0]             hold_data_q, hold_data_d;
  logic                    load_pending;
  logic [31:0]             ld_word;
  logic [31:0]             ld_result;
  logic [31:0]             ex_mem_out;
  memory2_writeback_pass_t pass_out_w;

  assign load_pending = ld_pending(pass_in_q);

  assign stall_o = stall_i
                 | ((state_q == WAIT) & ~bus.dcache_data_valid)
                 | (state_q == DROP);

  always_comb begin
    pass_in_d   = pass_in_q;
    state_d     = state_q;
    hold_data_d = hold_data_q;
    if (flush_i) begin
      pass_in_d       = bus.pass_in;
      pass_in_d.valid = 1'b0;
      // Only an issued load with its response still in flight needs DROP.
      state_d = ((state_q == WAIT) && !bus.dcache_data_valid) ? DROP : IDLE;
    end else if (!stall_o) begin
      pass_in_d = bus.pass_in;
      state_d   = ld_pending(bus.pass_in) ? WAIT : IDLE;
    end else begin
      case (state_q)
        WAIT: begin
          if (bus.dcache_data_valid) begin
            state_d     = HOLD;
            hold_data_d = bus.dcache_rdata;
          end
        end
        DROP: begin
          if (bus.dcache_data_valid) state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_in_q   <= '0;
      state_q     <= IDLE;
      hold_data_q <= '0;
    end else begin
      pass_in_q   <= pass_in_d;
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
    end
  end

  assign ld_word = (state_q == HOLD) ? hold_data_q : bus.dcache_rdata;

  load_align u_load_align (
    .rdata_i     (ld_word),
    .va_i        (pass_in_q.va[1:0]),
    .ld_size_i   (pass_in_q.ld_size),
    .ld_signed_i (pass_in_q.ld_signed),
    .result_o    (ld_result)
  );

  assign ex_mem_out = load_pending ? ld_result : pass_in_q.ex_out;

  always_comb begin
    pass_out_w            = '0;
    pass_out_w.valid      = pass_in_q.valid & ~stall_o;
    pass_out_w.pc         = pass_in_q.pc;
    pass_out_w.is_ld      = pass_in_q.is_ld;
    pass_out_w.va         = pass_in_q.va;
    pass_out_w.ex_mem_out = ex_mem_out;
    pass_out_w.is_wr_rd   = pass_in_q.is_wr_rd;
    pass_out_w.rd         = pass_in_q.rd;
    pass_out_w.excp_event = pass_in_q.excp_event;
  end

  assign bus.pass_out = pass_out_w;

`ifdef MEM2_FWD_EN
  assign fwd_valid = pass_in_q.valid & pass_in_q.is_wr_rd
                   & ~((state_q == WAIT) & ~bus.dcache_data_valid)
                   & (state_q != DROP);
  assign fwd_rd    = pass_in_q.rd;
  assign fwd_data  = ex_mem_out;
`endif

endmodule

// File: tb/tb_memory2.sv
module tb_memory2;
  import cpu_defs::*;

  logic clk = 1'b0;
  logic rst_n;
  logic flush_i;
  logic stall_i;
  logic stall_o;

  memory2_if bus ();

`ifdef MEM2_FWD_EN
  logic        fwd_valid;
  reg_idx_t    fwd_rd;
  logic [31:0] fwd_data;
`endif

  memory2 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_i),
    .stall_i (stall_i),
    .stall_o (stall_o),
    .bus     (bus)
`ifdef MEM2_FWD_EN
    ,
    .fwd_valid (fwd_valid),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: the held instruction, whether its response has been
  // received (and the word), and how many flushed-away responses are owed.
  memory1_memory2_pass_t m_slot;
  bit                    m_got;
  logic [31:0]           m_data;
  int                    m_orphan;
  bit                    m_stall;
  int                    resp_cnt;
  bit                    rnd_mode;

  function automatic bit wants_resp(input memory1_memory2_pass_t p);
    return p.valid && p.is_ld && !p.excp_event.valid;
  endfunction

  function automatic logic [31:0] m_align(input logic [31:0] w, input logic [1:0] off,
                                          input ld_size_t sz, input bit sgn);
    longint v;
    int     bits;
    int     shamt;
    if (sz == LD_W) return w;
    bits  = (sz == LD_B) ? 8 : 16;
    shamt = (sz == LD_B) ? 8 * int'(off) : 16 * int'(off[1]);
    v = longint'(w >> shamt) % (longint'(1) << bits);
    if (sgn && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    return 32'(v);
  endfunction

  function automatic memory1_memory2_pass_t mk_ld(input ld_size_t sz, input bit sgn,
                                                  input logic [31:0] va, input bit exc);
    memory1_memory2_pass_t p;
    p                  = '0;
    p.valid            = 1'b1;
    p.pc               = 32'h0000_1000 + va;
    p.is_ld            = 1'b1;
    p.ld_size          = sz;
    p.ld_signed        = sgn;
    p.va               = va;
    p.ex_out           = 32'hDEAD_0000;
    p.is_wr_rd         = 1'b1;
    p.rd               = 5'd7;
    p.excp_event.valid = exc;
    p.excp_event.cause = exc ? 5'd5 : 5'd0;
    return p;
  endfunction

  function automatic memory1_memory2_pass_t mk_alu();
    memory1_memory2_pass_t p;
    p          = '0;
    p.valid    = 1'b1;
    p.pc       = 32'h0000_2000;
    p.ex_out   = 32'h0BAD_F00D;
    p.is_wr_rd = 1'b1;
    p.rd       = 5'd3;
    return p;
  endfunction

  function automatic memory1_memory2_pass_t rand_pass();
    memory1_memory2_pass_t p;
    p                  = '0;
    p.valid            = ($urandom_range(0, 3) != 0);
    p.pc               = $urandom;
    p.is_ld            = ($urandom_range(0, 1) != 0);
    p.ld_size          = ld_size_t'($urandom_range(0, 2));
    p.ld_signed        = ($urandom_range(0, 1) != 0);
    p.va               = $urandom;
    if (p.ld_size == LD_H) p.va[0] = 1'b0;
    if (p.ld_size == LD_W) p.va[1:0] = 2'b00;
    p.ex_out           = $urandom;
    p.is_wr_rd         = ($urandom_range(0, 1) != 0);
    p.rd               = 5'($urandom);
    p.excp_event.valid = ($urandom_range(0, 9) == 0);
    p.excp_event.cause = 5'($urandom);
    return p;
  endfunction

  // Called at a falling edge: apply inputs, then compare outputs with the model.
  task automatic drive(input bit fl, input bit st, input bit dv, input logic [31:0] rdata,
                       input memory1_memory2_pass_t pin);
    bit          need;
    bit          exp_valid;
    logic [31:0] exp_out;
    flush_i               = fl;
    stall_i               = st;
    bus.dcache_data_valid = dv;
    bus.dcache_rdata      = rdata;
    bus.pass_in           = pin;
    #1;
    need      = wants_resp(m_slot);
    m_stall   = st || (need && !m_got && !dv) || (m_orphan > 0);
    exp_valid = m_slot.valid && !m_stall;
    check_eq("stall_o", 32'(stall_o), 32'(m_stall));
    check_eq("valid", 32'(bus.pass_out.valid), 32'(exp_valid));
    if (exp_valid) begin
      exp_out = need ? m_align(m_got ? m_data : rdata, m_slot.va[1:0], m_slot.ld_size,
                               m_slot.ld_signed)
                     : m_slot.ex_out;
      check_eq("ex_mem_out", bus.pass_out.ex_mem_out, exp_out);
      check_eq("rd", 32'(bus.pass_out.rd), 32'(m_slot.rd));
      check_eq("excp_event", 32'(bus.pass_out.excp_event), 32'(m_slot.excp_event));
      check_eq("pc", bus.pass_out.pc, m_slot.pc);
    end
  endtask

  // Advance one clock and update the model from the inputs of that cycle.
  task automatic tick();
    bit need;
    bit orphaned;
    @(posedge clk);
    need     = wants_resp(m_slot);
    orphaned = need && !m_got && !bus.dcache_data_valid;
    if (bus.dcache_data_valid) begin
      if (m_orphan > 0) m_orphan--;
      else if (need && !m_got) begin
        m_got  = 1'b1;
        m_data = bus.dcache_rdata;
      end
    end
    if (resp_cnt >= 0) resp_cnt--;
    if (flush_i) begin
      if (orphaned) m_orphan++;
      m_slot       = bus.pass_in;
      m_slot.valid = 1'b0;
      m_got        = 1'b0;
    end else if (!m_stall) begin
      m_slot = bus.pass_in;
      m_got  = 1'b0;
      if (rnd_mode && wants_resp(m_slot)) resp_cnt = int'($urandom_range(0, 3));
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_slot   = '0;
    m_got    = 1'b0;
    m_data   = '0;
    m_orphan = 0;
    resp_cnt = -1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    memory1_memory2_pass_t nop;
    nop                   = '0;
    rnd_mode              = 1'b0;
    model_reset();
    rst_n                 = 1'b0;
    flush_i               = 1'b0;
    stall_i               = 1'b1;
    bus.dcache_data_valid = 1'b0;
    bus.dcache_rdata      = '0;
    bus.pass_in           = '0;
    #1;
    check_eq("rst_stall_follows_1", 32'(stall_o), 32'd1);
    check_eq("rst_valid", 32'(bus.pass_out.valid), 32'd0);
    stall_i = 1'b0;
    #1;
    check_eq("rst_stall_follows_0", 32'(stall_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Byte load hit, signed then unsigned.
    drive(0, 0, 0, 32'h0, mk_ld(LD_B, 1'b1, 32'h0000_1003, 1'b0)); tick();
    drive(0, 0, 1, 32'h80FF_1234, nop);
    check_eq("lb_signed", bus.pass_out.ex_mem_out, 32'hFFFF_FF80);
    check_eq("lb_hit_nostall", 32'(stall_o), 32'd0);
    tick();
    drive(0, 0, 0, 32'h0, mk_ld(LD_B, 1'b0, 32'h0000_1003, 1'b0)); tick();
    drive(0, 0, 1, 32'h80FF_1234, nop);
    check_eq("lbu", bus.pass_out.ex_mem_out, 32'h0000_0080);
    tick();

    // Half load, three-cycle miss.
    drive(0, 0, 0, 32'h0, mk_ld(LD_H, 1'b0, 32'h0000_2002, 1'b0)); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, $urandom, nop);
      check_eq("lhu_miss_stall", 32'(stall_o), 32'd1);
      tick();
    end
    drive(0, 0, 1, 32'h8001_0000, nop);
    check_eq("lhu_miss_data", bus.pass_out.ex_mem_out, 32'h0000_8001);
    check_eq("lhu_miss_valid", 32'(bus.pass_out.valid), 32'd1);
    tick();
    drive(0, 0, 0, 32'h0, nop);
    check_eq("lhu_one_shot", 32'(bus.pass_out.valid), 32'd0);
    tick();

    // Response under downstream stall is held.
    drive(0, 0, 0, 32'h0, mk_ld(LD_W, 1'b0, 32'h0000_3000, 1'b0)); tick();
    drive(0, 1, 1, 32'hCAFE_BABE, nop); tick();
    repeat (2) begin drive(0, 1, 0, $urandom, nop); tick(); end
    drive(0, 0, 0, 32'h1234_5678, nop);
    check_eq("hold_data", bus.pass_out.ex_mem_out, 32'hCAFE_BABE);
    check_eq("hold_valid", 32'(bus.pass_out.valid), 32'd1);
    tick();

    // Flush with an outstanding miss; orphan response arrives two cycles later.
    drive(0, 0, 0, 32'h0, mk_ld(LD_W, 1'b0, 32'h0000_4000, 1'b0)); tick();
    drive(1, 0, 0, 32'h0, nop);
    check_eq("flush_wait_stall", 32'(stall_o), 32'd1);
    tick();
    drive(0, 0, 0, 32'h0, nop);
    check_eq("drop_stall", 32'(stall_o), 32'd1);
    tick();
    drive(0, 0, 1, 32'hBAD0_BAD0, mk_ld(LD_W, 1'b0, 32'h0000_4400, 1'b0));
    check_eq("orphan_no_valid", 32'(bus.pass_out.valid), 32'd0);
    tick();
    check_eq("drop_to_idle", 32'(dut.state_q), 32'(IDLE));
    drive(0, 0, 0, 32'h0, mk_ld(LD_W, 1'b0, 32'h0000_4400, 1'b0)); tick();
    drive(0, 0, 1, 32'h1122_3344, nop);
    check_eq("post_drop_data", bus.pass_out.ex_mem_out, 32'h1122_3344);
    tick();

    // Excepting load: no stall, passes straight through.
    drive(0, 0, 0, 32'h0, mk_ld(LD_W, 1'b1, 32'h0000_5000, 1'b1)); tick();
    drive(0, 0, 0, 32'h0, nop);
    check_eq("excp_nostall", 32'(stall_o), 32'd0);
    check_eq("excp_valid", 32'(bus.pass_out.valid), 32'd1);
    check_eq("excp_event", 32'(bus.pass_out.excp_event), 32'h25);
    check_eq("excp_ex_out", bus.pass_out.ex_mem_out, 32'hDEAD_0000);
    tick();

    // Flush beats stall with a valid non-load held.
    drive(0, 0, 0, 32'h0, mk_alu()); tick();
    drive(1, 1, 0, 32'h0, nop); tick();
    drive(0, 0, 0, 32'h0, nop);
    check_eq("flush_over_stall", 32'(bus.pass_out.valid), 32'd0);
    tick();

    // Reset while in HOLD.
    drive(0, 0, 0, 32'h0, mk_ld(LD_W, 1'b0, 32'h0000_6000, 1'b0)); tick();
    drive(0, 1, 1, 32'h0000_0077, nop); tick();
    drive(0, 1, 0, 32'h0, nop);
    check_eq("in_hold", 32'(dut.state_q), 32'(HOLD));
    rst_n = 1'b0;
    #1;
    check_eq("rst_hold_valid", 32'(bus.pass_out.valid), 32'd0);
    check_eq("rst_hold_state", 32'(dut.state_q), 32'(IDLE));
    check_eq("rst_hold_stall", 32'(stall_o), 32'd1);
    model_reset();
    @(negedge clk);
    rst_n   = 1'b1;
    stall_i = 1'b0;

    // Randomized traffic with a D-cache that answers each issued load once.
    rnd_mode = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      bit fl;
      bit st;
      bit dv;
      fl = (m_orphan == 0) && ($urandom_range(0, 9) == 0);
      st = ($urandom_range(0, 3) == 0);
      dv = (resp_cnt == 0);
      drive(fl, st, dv, $urandom, rand_pass());
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
